// File: rtl/mw_stage_pkg.sv
// ---------------------------------------------------------------------------
// mw_stage_pkg
//   Shared encodings for the memory/writeback stage of the 3-stage RV32I
//   pipeline: writeback source select, load funct3 values and the
//   stall-handshake FSM states. Imported by mw_stage and load_extract.
// ---------------------------------------------------------------------------
package mw_stage_pkg;

    // Writeback source select. Value 3 is reserved and behaves like WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3
    } wb_sel_e;

    // Load width/sign field (funct3 of the LOAD opcode).
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    // Data-cache handshake states.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } mw_state_e;

    // A register write is only architecturally visible when a real
    // instruction that writes rd reaches MW, rd is not x0, and the cache is
    // not holding the pipeline.
    function automatic logic rd_write_en(
        input logic       valid,
        input logic       rwe,
        input logic [4:0] rd,
        input logic       stall
    );
        return valid & rwe & (rd != 5'd0) & ~stall;
    endfunction

endpackage : mw_stage_pkg

// File: rtl/mw_stage_load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
//   Combinational load aligner. Picks the byte / halfword / word addressed
//   by the low address bits out of the cache read word and sign- or
//   zero-extends it according to funct3.
//
// Ports
//   word    in   DWIDTH  cache read word
//   off     in   2       effective address bits [1:0]
//   funct3  in   3       load width/sign field
//   data    out  DWIDTH  aligned, extended load data
// ---------------------------------------------------------------------------
module load_extract
    import mw_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DWIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default on
        // entry; a path that leaves one unassigned would infer a latch.
        byte_sel = word[7:0];
        half_sel = word[15:0];
        data     = word;

        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase

        // off[0] is ignored for halfwords: a misaligned LH reads the
        // halfword that encloses the addressed byte.
        if (off[1]) begin
            half_sel = word[31:16];
        end

        case (funct3)
            FNC_LB:  data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            FNC_LBU: data = {{(DWIDTH-8){1'b0}}, byte_sel};
            FNC_LH:  data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            FNC_LHU: data = {{(DWIDTH-16){1'b0}}, half_sel};
            // LW and every unused funct3 value return the whole word.
            default: data = word;
        endcase
    end

endmodule : load_extract

// File: rtl/mw_stage.sv
// ---------------------------------------------------------------------------
// mw_stage
//   Stage 3 (memory/writeback) of the 3-stage RV32I pipeline. Registers the
//   X-stage result, freezes on the data-cache stall handshake, aligns load
//   data and selects the writeback value. Also keeps the cycle, instret and
//   stalled-cycle performance counters.
//
// Ports
//   clk           in   1          rising-edge clock
//   reset         in   1          synchronous, active-high reset
//   x_valid       in   1          X stage holds a real instruction
//   x_alu_out     in   DWIDTH     ALU result / load-store effective address
//   x_pc          in   DWIDTH     PC of the X-stage instruction
//   x_rd          in   5          destination register index
//   x_rwe         in   1          instruction writes rd
//   x_wb_sel      in   2          writeback source (ALU/MEM/PC+4/reserved)
//   x_funct3      in   3          load width/sign field
//   dcache_dout   in   DWIDTH     cache read word for the load in MW
//   dcache_stall  in   1          cache busy/missing, whole pipe freezes
//   rd_mw         out  5          registered destination index
//   rwe_mw        out  1          qualified register-file write enable
//   wb_data       out  DWIDTH     writeback value
//   pipe_stall    out  1          freeze request to stages 1-2
//   csr_cycle     out  CNT_WIDTH  cycle counter
//   csr_instret   out  CNT_WIDTH  retired-instruction counter
//   csr_stall     out  CNT_WIDTH  stalled-cycle counter
// ---------------------------------------------------------------------------
module mw_stage
    import mw_stage_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x_valid,
    input  logic [DWIDTH-1:0]    x_alu_out,
    input  logic [DWIDTH-1:0]    x_pc,
    input  logic [4:0]           x_rd,
    input  logic                 x_rwe,
    input  logic [1:0]           x_wb_sel,
    input  logic [2:0]           x_funct3,
    input  logic [DWIDTH-1:0]    dcache_dout,
    input  logic                 dcache_stall,
    output logic [4:0]           rd_mw,
    output logic                 rwe_mw,
    output logic [DWIDTH-1:0]    wb_data,
    output logic                 pipe_stall,
    output logic [CNT_WIDTH-1:0] csr_cycle,
    output logic [CNT_WIDTH-1:0] csr_instret,
    output logic [CNT_WIDTH-1:0] csr_stall
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    mw_state_e             state_q,      state_d;

    logic                  mw_valid_q,   mw_valid_d;
    logic [DWIDTH-1:0]     mw_alu_out_q, mw_alu_out_d;
    logic [DWIDTH-1:0]     mw_pc_q,      mw_pc_d;
    logic [4:0]            mw_rd_q,      mw_rd_d;
    logic                  mw_rwe_q,     mw_rwe_d;
    wb_sel_e               mw_wb_sel_q,  mw_wb_sel_d;
    logic [2:0]            mw_funct3_q,  mw_funct3_d;

    logic [CNT_WIDTH-1:0]  cycle_q,      cycle_d;
    logic [CNT_WIDTH-1:0]  instret_q,    instret_d;
    logic [CNT_WIDTH-1:0]  stall_q,      stall_d;

    logic [DWIDTH-1:0]     load_data;
    logic                  retire;

    // An instruction retires in any cycle where MW holds a real instruction
    // and the cache lets it leave; this includes the cycle a miss resolves.
    assign retire = mw_valid_q & ~dcache_stall;

    // -----------------------------------------------------------------------
    // Stall-handshake FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (dcache_stall)  state_d = ST_MISS;
            ST_MISS: if (!dcache_stall) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pipeline register next values: capture X unless the cache holds us
    // -----------------------------------------------------------------------
    always_comb begin
        mw_valid_d   = mw_valid_q;
        mw_alu_out_d = mw_alu_out_q;
        mw_pc_d      = mw_pc_q;
        mw_rd_d      = mw_rd_q;
        mw_rwe_d     = mw_rwe_q;
        mw_wb_sel_d  = mw_wb_sel_q;
        mw_funct3_d  = mw_funct3_q;

        if (!dcache_stall) begin
            mw_valid_d   = x_valid;
            mw_alu_out_d = x_alu_out;
            mw_pc_d      = x_pc;
            mw_rd_d      = x_rd;
            mw_rwe_d     = x_rwe;
            mw_wb_sel_d  = wb_sel_e'(x_wb_sel);
            mw_funct3_d  = x_funct3;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters: free-running, wrap at 2^CNT_WIDTH
    // -----------------------------------------------------------------------
    always_comb begin
        cycle_d   = cycle_q + CNT_WIDTH'(1);
        stall_d   = stall_q + CNT_WIDTH'(dcache_stall);
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the whole MW register is cleared, not just the valid bit,
            // so rd_mw and wb_data read zero straight out of reset and a
            // reset taken during a miss cannot leave a stale write behind.
            state_q      <= ST_RUN;
            mw_valid_q   <= 1'b0;
            mw_alu_out_q <= '0;
            mw_pc_q      <= '0;
            mw_rd_q      <= '0;
            mw_rwe_q     <= 1'b0;
            mw_wb_sel_q  <= WB_ALU;
            mw_funct3_q  <= '0;
            cycle_q      <= '0;
            instret_q    <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            mw_valid_q   <= mw_valid_d;
            mw_alu_out_q <= mw_alu_out_d;
            mw_pc_q      <= mw_pc_d;
            mw_rd_q      <= mw_rd_d;
            mw_rwe_q     <= mw_rwe_d;
            mw_wb_sel_q  <= mw_wb_sel_d;
            mw_funct3_q  <= mw_funct3_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
            stall_q      <= stall_d;
        end
    end

    // -----------------------------------------------------------------------
    // Load alignment and writeback select
    // -----------------------------------------------------------------------
    load_extract #(
        .DWIDTH (DWIDTH)
    ) u_load_extract (
        .word   (dcache_dout),
        .off    (mw_alu_out_q[1:0]),
        .funct3 (mw_funct3_q),
        .data   (load_data)
    );

    always_comb begin
        wb_data = mw_alu_out_q;
        case (mw_wb_sel_q)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = mw_pc_q + DWIDTH'(4);
            WB_ALU,
            WB_RSV:  wb_data = mw_alu_out_q;
            default: wb_data = mw_alu_out_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The stall is passed through combinationally so stages 1-2 freeze in
    // the same cycle the cache raises it.
    assign pipe_stall  = dcache_stall;
    assign rd_mw       = mw_rd_q;
    // Suppressed while stalled: the held load's data is not valid yet, and
    // the same signal gates stage-2 forwarding.
    assign rwe_mw      = rd_write_en(mw_valid_q, mw_rwe_q, mw_rd_q, dcache_stall);
    assign csr_cycle   = cycle_q;
    assign csr_instret = instret_q;
    assign csr_stall   = stall_q;

endmodule : mw_stage

// File: tb/tb_mw_stage.sv
// ---------------------------------------------------------------------------
// tb_mw_stage
//   Directed self-checking bench for mw_stage. Each instruction driven into
//   X pushes its expected writeback onto a scoreboard queue; the entry at
//   the head describes the instruction currently in MW and is popped when
//   that instruction leaves (any unstalled cycle). Counters are tracked by a
//   small reference model updated once per cycle.
// ---------------------------------------------------------------------------
module tb_mw_stage;
    import mw_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0;
    logic [31:0] x_alu_out = '0;
    logic [31:0] x_pc = '0;
    logic [4:0]  x_rd = '0;
    logic        x_rwe = 1'b0;
    logic [1:0]  x_wb_sel = '0;
    logic [2:0]  x_funct3 = '0;
    logic [31:0] dcache_dout = '0;
    logic        dcache_stall = 1'b0;
    logic [4:0]  rd_mw;
    logic        rwe_mw;
    logic [31:0] wb_data;
    logic        pipe_stall;
    logic [31:0] csr_cycle;
    logic [31:0] csr_instret;
    logic [31:0] csr_stall;

    mw_stage dut (
        .clk          (clk),
        .reset        (reset),
        .x_valid      (x_valid),
        .x_alu_out    (x_alu_out),
        .x_pc         (x_pc),
        .x_rd         (x_rd),
        .x_rwe        (x_rwe),
        .x_wb_sel     (x_wb_sel),
        .x_funct3     (x_funct3),
        .dcache_dout  (dcache_dout),
        .dcache_stall (dcache_stall),
        .rd_mw        (rd_mw),
        .rwe_mw       (rwe_mw),
        .wb_data      (wb_data),
        .pipe_stall   (pipe_stall),
        .csr_cycle    (csr_cycle),
        .csr_instret  (csr_instret),
        .csr_stall    (csr_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          id;
        logic        valid;
        logic        strict;   // check rd/wb even for a bubble (post-reset zeros)
        logic [4:0]  rd;
        logic        rwe;      // expected rwe_mw when unstalled
        logic [31:0] wb;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        cur_stall = 1'b0;
    logic [31:0] m_cycle = '0;
    logic [31:0] m_instret = '0;
    logic [31:0] m_stall = '0;

    localparam logic [31:0] DOUT = 32'h80FF7F01;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Compare MW outputs against the scoreboard head at the falling edge.
    task automatic check_mw();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e = exp_q[0];
        check($sformatf("i%0d.pipe_stall", e.id), 32'(pipe_stall), 32'(cur_stall));
        if (cur_stall) begin
            check($sformatf("i%0d.rwe_stalled", e.id), 32'(rwe_mw), 32'd0);
        end else begin
            check($sformatf("i%0d.rwe_mw", e.id), 32'(rwe_mw), 32'(e.rwe));
        end
        if (e.valid || e.strict) begin
            check($sformatf("i%0d.rd_mw", e.id), 32'(rd_mw), 32'(e.rd));
            check($sformatf("i%0d.wb_data", e.id), wb_data, e.wb);
        end
        check($sformatf("i%0d.csr_cycle", e.id), csr_cycle, m_cycle);
        check($sformatf("i%0d.csr_instret", e.id), csr_instret, m_instret);
        check($sformatf("i%0d.csr_stall", e.id), csr_stall, m_stall);
        // Model the effect of the coming edge.
        m_cycle++;
        if (cur_stall) begin
            m_stall++;
        end else begin
            if (e.valid) m_instret++;
            void'(exp_q.pop_front());
        end
    endtask

    // New X instruction this cycle (X is only changed after an unstalled cycle).
    task automatic cyc_issue(input logic stall, input int id, input logic valid,
                             input logic [4:0] rd, input logic rwe, input logic [1:0] sel,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] pc, input logic [31:0] exp_wb);
        exp_t e;
        @(posedge clk);
        #1;
        cur_stall    = stall;
        dcache_stall = stall;
        dcache_dout  = DOUT;
        x_valid      = valid;
        x_rd         = rd;
        x_rwe        = rwe;
        x_wb_sel     = sel;
        x_funct3     = f3;
        x_alu_out    = alu;
        x_pc         = pc;
        e.id     = id;
        e.valid  = valid;
        e.strict = 1'b0;
        e.rd     = rd;
        e.rwe    = valid & rwe & (rd != 5'd0);
        e.wb     = exp_wb;
        exp_q.push_back(e);
        check_mw();
    endtask

    // X holds its previous instruction this cycle.
    task automatic cyc_hold(input logic stall);
        @(posedge clk);
        #1;
        cur_stall    = stall;
        dcache_stall = stall;
        dcache_dout  = DOUT;
        check_mw();
    endtask

    task automatic do_reset(input logic stall);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = 1'b1;
        x_valid      = 1'b0;
        cur_stall    = stall;
        dcache_stall = stall;
        @(negedge clk);
        check("reset.pipe_stall", 32'(pipe_stall), 32'(stall));
        @(posedge clk);
        #1;
        reset        = 1'b0;
        cur_stall    = 1'b0;
        dcache_stall = 1'b0;
        x_rd = '0; x_rwe = 1'b0; x_wb_sel = '0; x_funct3 = '0; x_alu_out = '0; x_pc = '0;
        exp_q.delete();
        m_cycle = '0; m_instret = '0; m_stall = '0;
        e = '{id: 0, valid: 1'b0, strict: 1'b1, rd: 5'd0, rwe: 1'b0, wb: 32'd0};
        exp_q.push_back(e);
        e.strict = 1'b0;
        exp_q.push_back(e);
        check_mw();
        check("reset.state", 32'(dut.state_q), 32'(ST_RUN));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(1'b0);
        //         stall id valid rd  rwe sel  f3      alu            pc             expected wb
        cyc_issue(0,  1, 1, 5'd5,  1, 2'd0, FNC_LW,  32'h0000_1234, 32'h0,         32'h0000_1234);
        cyc_issue(0,  2, 1, 5'd6,  1, 2'd1, FNC_LB,  32'h0000_1002, 32'h0,         32'hFFFF_FFFF);
        cyc_issue(0,  3, 1, 5'd7,  1, 2'd1, FNC_LBU, 32'h0000_1002, 32'h0,         32'h0000_00FF);
        cyc_issue(0,  4, 1, 5'd8,  1, 2'd1, FNC_LH,  32'h0000_1002, 32'h0,         32'hFFFF_80FF);
        cyc_issue(0,  5, 1, 5'd9,  1, 2'd1, FNC_LHU, 32'h0000_1002, 32'h0,         32'h0000_80FF);
        cyc_issue(0,  6, 1, 5'd10, 1, 2'd1, FNC_LW,  32'h0000_1003, 32'h0,         32'h80FF_7F01);
        cyc_issue(0,  7, 1, 5'd12, 1, 2'd1, FNC_LH,  32'h0000_1003, 32'h0,         32'hFFFF_80FF);
        cyc_issue(0,  8, 1, 5'd13, 1, 2'd1, FNC_LB,  32'h0000_1003, 32'h0,         32'hFFFF_FF80);
        cyc_issue(0,  9, 1, 5'd14, 1, 2'd1, 3'b110,  32'h0000_1001, 32'h0,         32'h80FF_7F01);
        cyc_issue(0, 10, 1, 5'd1,  1, 2'd2, FNC_LW,  32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000);
        cyc_issue(0, 11, 1, 5'd2,  1, 2'd2, FNC_LW,  32'h0000_0000, 32'h0000_0100, 32'h0000_0104);
        cyc_issue(0, 12, 1, 5'd0,  1, 2'd0, FNC_LW,  32'h0000_DEAD, 32'h0,         32'h0000_DEAD);
        cyc_issue(0, 13, 1, 5'd11, 1, 2'd3, FNC_LB,  32'h0000_55AA, 32'h0,         32'h0000_55AA);
        cyc_issue(0, 14, 1, 5'd4,  0, 2'd0, FNC_LW,  32'h0000_0009, 32'h0,         32'h0000_0009);
        cyc_issue(0, 15, 1, 5'd15, 1, 2'd1, FNC_LBU, 32'h0000_2001, 32'h0,         32'h0000_007F);
        // LBU now in MW; the cache stalls for three cycles while a new
        // instruction sits in X.
        cyc_issue(1, 16, 1, 5'd16, 1, 2'd0, FNC_LW,  32'h0000_0777, 32'h0,         32'h0000_0777);
        cyc_hold(1);
        check("stall.state", 32'(dut.state_q), 32'(ST_MISS));
        cyc_hold(1);
        cyc_hold(0);   // LBU retires; instruction 16 captured at this edge
        // Bubble in MW meets a stall: counted as a stall, not as a retire.
        cyc_issue(0, 17, 0, 5'd3,  1, 2'd0, FNC_LW,  32'h0000_0BAD, 32'h0,         32'h0000_0BAD);
        cyc_issue(1, 18, 1, 5'd17, 1, 2'd0, FNC_LW,  32'h0000_0042, 32'h0,         32'h0000_0042);
        cyc_hold(0);
        // Reset taken while a load waits on a miss.
        cyc_issue(0, 19, 1, 5'd18, 1, 2'd1, FNC_LW,  32'h0000_0000, 32'h0,         32'h80FF_7F01);
        cyc_issue(1, 20, 1, 5'd19, 1, 2'd0, FNC_LW,  32'h0000_0005, 32'h0,         32'h0000_0005);
        do_reset(1'b1);
        cyc_issue(0, 21, 1, 5'd3,  1, 2'd0, FNC_LW,  32'hCAFE_0000, 32'h0,         32'hCAFE_0000);
        cyc_issue(0, 22, 0, 5'd0,  0, 2'd0, FNC_LW,  32'h0000_0000, 32'h0,         32'h0000_0000);
        cyc_issue(0, 23, 0, 5'd0,  0, 2'd0, FNC_LW,  32'h0000_0000, 32'h0,         32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mw_stage
